// File: rtl/telemetry_framer_pkg.sv
// Shared constants, FSM state type and the frame byte mux for the eBike
// telemetry framer.
package eBike_telem_pkg;

    localparam logic [7:0] SYNC0     = 8'hAA;
    localparam logic [7:0] SYNC1     = 8'h55;
    localparam int         FRM_BYTES = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } telem_state_t;

    // Select frame byte idx from a {batt, curr, torque} snapshot.
    // Upper-nibble bytes are zero-padded so nothing above bit 11 can leak.
    function automatic logic [7:0] frame_byte(input logic [2:0]  idx,
                                              input logic [35:0] snap);
        logic [7:0] b;
        case (idx)
            3'd0:    b = SYNC0;
            3'd1:    b = SYNC1;
            3'd2:    b = {4'h0, snap[35:32]};
            3'd3:    b = snap[31:24];
            3'd4:    b = {4'h0, snap[23:20]};
            3'd5:    b = snap[19:12];
            3'd6:    b = {4'h0, snap[11:8]};
            default: b = snap[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/telemetry_framer_uart_tx_core.sv
// 8N1 UART transmitter, LSB first. Loads a byte on trmt, shifts it out at
// BAUD_DIV clocks per bit and pulses tx_done as the stop bit period ends.
module uart_tx_core #(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int BW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

    logic [BW-1:0] baud_q;
    logic [3:0]    bit_q;
    logic [9:0]    shift_q;
    logic          busy_q;
    logic          tx_q;
    logic          baud_tc;

    assign baud_tc = busy_q && (baud_q == BW'(BAUD_DIV - 1));
    // Terminal count of the tenth bit: the stop bit has been held long enough.
    assign tx_done = baud_tc && (bit_q == 4'd9);
    assign tx_busy = busy_q;
    assign TX      = tx_q;

    // Load {stop, data, start} on trmt, then shift right once per bit period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '1;
            busy_q  <= 1'b0;
            baud_q  <= '0;
            bit_q   <= 4'd0;
        end else if (trmt && !busy_q) begin
            shift_q <= {1'b1, tx_data, 1'b0};
            busy_q  <= 1'b1;
            baud_q  <= '0;
            bit_q   <= 4'd0;
        end else if (busy_q) begin
            if (baud_tc) begin
                baud_q  <= '0;
                shift_q <= {1'b1, shift_q[9:1]};
                if (bit_q == 4'd9) begin
                    busy_q <= 1'b0;
                    bit_q  <= 4'd0;
                end else begin
                    bit_q <= bit_q + 4'd1;
                end
            end else begin
                baud_q <= baud_q + BW'(1);
            end
        end
    end

    // Output flop keeps the line glitch-free; reset drives it high at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_q <= 1'b1;
        end else begin
            tx_q <= shift_q[0];
        end
    end

endmodule

// File: rtl/telemetry_framer.sv
// Periodic telemetry framer: snapshots battery voltage, motor current and
// pedal torque on each period tick and sends them as an 8-byte UART frame.
module telemetry_framer
    import eBike_telem_pkg::*;
#(
    parameter int PERIOD_W = 20,
    parameter int BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] batt_v,
    input  logic [11:0] avg_curr,
    input  logic [11:0] avg_torque,
    output logic        TX,
    output logic        frm_busy,
    output logic        frm_done,
    output logic        frm_ovr
);

    logic [PERIOD_W-1:0] period_q;
    logic                tick;

    telem_state_t state_q, state_d;
    logic [2:0]   idx_q, idx_d;
    logic [35:0]  snap_q, snap_d;
    logic         fin_q, fin_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         ovr_q, ovr_d;

    logic         trmt;
    logic [7:0]   tx_data;
    logic         tx_busy;
    logic         tx_done;

    assign tick     = &period_q;
    assign tx_data  = frame_byte(idx_q, snap_q);
    assign frm_busy = busy_q;
    assign frm_done = done_q;
    assign frm_ovr  = ovr_q;

    // Free-running frame period counter; wraps naturally at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_q <= '0;
        end else begin
            period_q <= period_q + PERIOD_W'(1);
        end
    end

    // Frame sequencing: snapshot on tick, then hand bytes to the UART one by one.
    // fin marks the last tx_done; busy/done follow it one clock later so they
    // line up with the end of the stop bit as seen on the TX pin.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        busy_d  = busy_q;
        fin_d   = 1'b0;
        trmt    = 1'b0;
        if (fin_q) begin
            busy_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (tick) begin
                    snap_d  = {batt_v, avg_curr, avg_torque};
                    idx_d   = 3'd0;
                    busy_d  = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (!tx_busy) begin
                    trmt    = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (tx_done) begin
                    if (idx_q == 3'(FRM_BYTES - 1)) begin
                        fin_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        done_d = fin_q;
        // A tick outside IDLE (including the tx_done edge of byte 7) is dropped.
        ovr_d  = tick && (state_q != IDLE);
    end

    // Framer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            snap_q  <= '0;
            fin_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            fin_q   <= fin_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    uart_tx_core #(
        .BAUD_DIV (BAUD_DIV)
    ) u_uart (
        .clk     (clk),
        .rst     (rst),
        .trmt    (trmt),
        .tx_data (tx_data),
        .TX      (TX),
        .tx_busy (tx_busy),
        .tx_done (tx_done)
    );

endmodule
